// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default width for down_counter_timer
package timer_pkg;
  localparam int TIMER_WIDTH_DEFAULT = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} timer_state_t;
endpackage

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with terminal-count pulse and optional auto-reload
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
  logic             tc_q, tc_d;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:
          if (!stop && start) begin
            state_d = (count_q != '0) ? ST_RUN : ST_DONE;
            tc_d    = (count_q == '0);
          end
        ST_RUN:
          if (stop) state_d = ST_IDLE;
          else if (count_q > WIDTH'(1)) count_d = count_q - WIDTH'(1);
          else begin
            tc_d    = 1'b1;
            count_d = auto_reload ? reload_q : '0;
            state_d = auto_reload ? ST_RUN : ST_DONE;
          end
        ST_DONE:
          if (!stop && start) begin
            count_d = reload_q;
            state_d = (reload_q != '0) ? ST_RUN : ST_DONE;
            tc_d    = (reload_q == '0);
          end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end
  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: table-driven scoreboard bench for down_counter_timer
module tb_down_counter_timer;
  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       st, sp, ar;
    logic [3:0] c;
    logic       b, d, t;
  } vec_t;
  typedef struct {
    logic [3:0] c;
    logic       b, d, t;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, auto_reload = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] count;
  logic       busy, tc, done;
  int         errors = 0;
  int         checks = 0;
  vec_t       vecs[$];
  exp_t       sb[$];
  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count), .busy(busy), .tc(tc), .done(done)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(int ld, int lv, int st, int sp, int ar, int c, int b, int d, int t);
    vec_t r;
    r.ld = ld[0]; r.lv = lv[3:0]; r.st = st[0]; r.sp = sp[0]; r.ar = ar[0];
    r.c = c[3:0]; r.b = b[0]; r.d = d[0]; r.t = t[0];
    return r;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " count"}, int'(count), int'(e.c));
    chk({tag, " busy"}, int'(busy), int'(e.b));
    chk({tag, " done"}, int'(done), int'(e.d));
    chk({tag, " tc"}, int'(tc), int'(e.t));
  endtask
  task automatic step(input int idx, input vec_t x);
    exp_t e;
    @(negedge clk);
    load = x.ld; load_value = x.lv; start = x.st; stop = x.sp; auto_reload = x.ar;
    e.c = x.c; e.b = x.b; e.d = x.d; e.t = x.t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL v%0d: scoreboard empty", idx);
    end else chk_all($sformatf("v%0d", idx), sb.pop_front());
  endtask
  task automatic idle_inputs();
    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; load_value = '0;
  endtask
  initial begin
    exp_t z;
    z.c = 4'd0; z.b = 1'b0; z.d = 1'b0; z.t = 1'b0;
    // from reset: start with count 0
    vecs.push_back(v(0,0,1,0,0, 0,0,1,1));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,0));
    // load 5, run to done
    vecs.push_back(v(1,5,0,0,0, 5,0,0,0));
    vecs.push_back(v(0,0,1,0,0, 5,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 4,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 3,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 2,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,1));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,0));
    // restart from done uses reload, start in run is harmless, stop holds
    vecs.push_back(v(0,0,1,0,0, 5,1,0,0));
    vecs.push_back(v(0,0,1,0,0, 4,1,0,0));
    vecs.push_back(v(0,0,0,1,0, 4,0,0,0));
    // load 6, stop at 2, pause, resume
    vecs.push_back(v(1,6,0,0,0, 6,0,0,0));
    vecs.push_back(v(0,0,1,0,0, 6,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 5,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 4,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 3,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 2,1,0,0));
    vecs.push_back(v(0,0,0,1,0, 2,0,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0,0,0,0,0, 2,0,0,0));
    vecs.push_back(v(0,0,1,0,0, 2,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,1));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,0));
    // auto-reload period 3, then drop auto_reload
    vecs.push_back(v(1,3,0,0,1, 3,0,0,0));
    vecs.push_back(v(0,0,1,0,1, 3,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 2,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 1,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 3,1,0,1));
    vecs.push_back(v(0,0,0,0,1, 2,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 1,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 3,1,0,1));
    vecs.push_back(v(0,0,0,0,1, 2,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,1));
    // load aborts run, load beats start, stop beats start, load beats stop
    vecs.push_back(v(1,6,0,0,0, 6,0,0,0));
    vecs.push_back(v(0,0,1,0,0, 6,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 5,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 4,1,0,0));
    vecs.push_back(v(1,15,0,0,0, 15,0,0,0));
    vecs.push_back(v(1,9,1,0,0, 9,0,0,0));
    vecs.push_back(v(0,0,0,0,0, 9,0,0,0));
    vecs.push_back(v(0,0,1,1,0, 9,0,0,0));
    vecs.push_back(v(0,0,1,0,0, 9,1,0,0));
    vecs.push_back(v(1,1,0,1,0, 1,0,0,0));
    // reload value 1 with auto-reload: tc every cycle
    vecs.push_back(v(0,0,1,0,1, 1,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 1,1,0,1));
    vecs.push_back(v(0,0,0,0,1, 1,1,0,1));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,1));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,0));
    // reload value 0: start from done re-pulses tc and stays done
    vecs.push_back(v(1,0,0,0,0, 0,0,0,0));
    vecs.push_back(v(0,0,1,0,0, 0,0,1,1));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,0));
    vecs.push_back(v(0,0,1,0,0, 0,0,1,1));
    vecs.push_back(v(0,0,0,0,0, 0,0,1,0));
    // set up run at 7 for the async reset check
    vecs.push_back(v(1,7,0,0,0, 7,0,0,0));
    vecs.push_back(v(0,0,1,0,0, 7,1,0,0));
    #1;
    chk_all("reset", z);
    #13;
    rst_n = 1'b1;
    foreach (vecs[i]) step(i, vecs[i]);
    // async reset mid-run at count 7, checked before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst_run", z);
    @(negedge clk);
    rst_n = 1'b1;
    // reset while tc is high discards it
    step(100, v(1,2,0,0,0, 2,0,0,0));
    step(101, v(0,0,1,0,0, 2,1,0,0));
    step(102, v(0,0,0,0,0, 1,1,0,0));
    step(103, v(0,0,0,0,0, 0,0,1,1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst_tc", z);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", z);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not end, expected finish");
    $fatal(1, "timeout");
  end
endmodule
